multi_cycle_ctrl: RTL

- Moore FSM that sequences the shared single-memory, single-ALU datapath of the multi-cycle CPU.
- Replaces the single-cycle combinational decoder: one instruction executes over 3–5 `clk` steps.
- Decodes the IR opcode and drives every mux select and write strobe for the PC, IR, register file, ALU and memory.
- Exports the current state, a retired-instruction counter and an illegal-opcode flag for the 7-seg/LED debug display.

---
 rtl/multi_cycle_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: a Moore FSM that sequences the shared memory/ALU
// datapath, plus a retired-instruction counter and a sticky illegal-opcode flag.
module multi_cycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       op,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_RTYPE:     state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Only lw and sw can reach MEMADR, so anything other than sw is lw.
        S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXEC:   state_q <= S_RWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_q     <= S_FETCH;
          instr_cnt_q <= instr_cnt_q + CNT_ONE;
        end
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  logic pc_write_d, pc_write_cond_d, mem_write_d, ir_write_d, reg_write_d;

  always_comb begin
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    mem_write_d     = 1'b0;
    ir_write_d      = 1'b0;
    reg_write_d     = 1'b0;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    ALUOp           = 2'b00;
    PCSource        = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
        ALUSrcB    = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_d = 1'b1;
        MemtoReg    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        IorD        = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        reg_write_d = 1'b1;
        RegDst      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUOp           = 2'b01;
        pc_write_cond_d = 1'b1;
        PCSource        = 2'b01;
      end
      S_JUMP: begin
        pc_write_d = 1'b1;
        PCSource   = 2'b10;
      end
      S_ADDIWB: reg_write_d = 1'b1;
      default: ;
    endcase
  end

  // A frozen step must not disturb architectural state, so every strobe is gated.
  assign PCWrite     = pc_write_d & en;
  assign PCWriteCond = pc_write_cond_d & en;
  assign MemWrite    = mem_write_d & en;
  assign IRWrite     = ir_write_d & en;
  assign RegWrite    = reg_write_d & en;

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;
  assign illegal   = illegal_q;

endmodule
